// File: rtl/ps2_host_transmitter.sv
// PS/2 host-to-device command transmitter: inhibits the bus, requests to send, then shifts one
// command byte out on device clock falling edges and collects the device ACK.
module ps2_host_transmitter #(
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned SETUP_CYCLES   = 100,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic       clock50,
    input  logic       reset,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    input  logic [7:0] cmd_byte,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    output logic       busy,
    output logic       done,
    output logic       error
);

    localparam int unsigned PhaseMax =
        (INHIBIT_CYCLES > SETUP_CYCLES) ? INHIBIT_CYCLES : SETUP_CYCLES;
    localparam int unsigned PhaseW   = $clog2(PhaseMax + 1);
    localparam int unsigned TimeoutW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [PhaseW-1:0]   InhibitLast = PhaseW'(INHIBIT_CYCLES - 1);
    localparam logic [PhaseW-1:0]   SetupLast   = PhaseW'(SETUP_CYCLES - 1);
    localparam logic [TimeoutW-1:0] TimeoutLast = TimeoutW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StInhibit,
        StRequest,
        StShift,
        StAck,
        StWaitIdle
    } state_t;

    state_t              state;
    logic [PhaseW-1:0]   phase_cnt;
    logic [TimeoutW-1:0] timeout_cnt;
    logic [3:0]          bit_cnt;
    logic [7:0]          cmd_q;

    logic [1:0] clk_sync, data_sync;
    logic [7:0] clk_hist, data_hist;
    logic       clk_filt, data_filt, clk_filt_prev;
    logic       clk_fall;
    logic       timed_out;

    // Synchronizers and glitch filters idle high, matching a released bus.
    always_ff @(posedge clock50) begin
        if (!reset) begin
            clk_sync      <= 2'b11;
            data_sync     <= 2'b11;
            clk_hist      <= 8'hFF;
            data_hist     <= 8'hFF;
            clk_filt      <= 1'b1;
            data_filt     <= 1'b1;
            clk_filt_prev <= 1'b1;
        end else begin
            clk_sync      <= {clk_sync[0], ps2_clk_in};
            data_sync     <= {data_sync[0], ps2_data_in};
            clk_hist      <= {clk_hist[6:0], clk_sync[1]};
            data_hist     <= {data_hist[6:0], data_sync[1]};
            clk_filt_prev <= clk_filt;
            if (&clk_hist) begin
                clk_filt <= 1'b1;
            end else if (~|clk_hist) begin
                clk_filt <= 1'b0;
            end
            if (&data_hist) begin
                data_filt <= 1'b1;
            end else if (~|data_hist) begin
                data_filt <= 1'b0;
            end
        end
    end

    assign clk_fall  = clk_filt_prev & ~clk_filt;
    assign timed_out = (timeout_cnt == TimeoutLast);
    assign cmd_ready = reset && (state == StIdle);
    assign busy      = (state != StIdle);

    always_ff @(posedge clock50) begin
        if (!reset) begin
            state       <= StIdle;
            phase_cnt   <= '0;
            timeout_cnt <= '0;
            bit_cnt     <= '0;
            cmd_q       <= '0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
        end else begin
            done  <= 1'b0;
            error <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (cmd_valid) begin
                        cmd_q       <= cmd_byte;
                        phase_cnt   <= '0;
                        ps2_clk_oe  <= 1'b1;
                        ps2_data_oe <= 1'b0;
                        state       <= StInhibit;
                    end
                end
                StInhibit: begin
                    if (phase_cnt == InhibitLast) begin
                        phase_cnt   <= '0;
                        ps2_data_oe <= 1'b1;
                        state       <= StRequest;
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end
                StRequest: begin
                    if (phase_cnt == SetupLast) begin
                        phase_cnt   <= '0;
                        ps2_clk_oe  <= 1'b0;
                        bit_cnt     <= '0;
                        timeout_cnt <= '0;
                        state       <= StShift;
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end
                StShift: begin
                    if (clk_fall) begin
                        timeout_cnt <= '0;
                        bit_cnt     <= bit_cnt + 1'b1;
                        if (bit_cnt < 4'd8) begin
                            ps2_data_oe <= ~cmd_q[bit_cnt[2:0]];
                        end else if (bit_cnt == 4'd8) begin
                            // Odd parity bit is ~^cmd_q; the line driver is its inverse.
                            ps2_data_oe <= ^cmd_q;
                        end else begin
                            ps2_data_oe <= 1'b0;
                            state       <= StAck;
                        end
                    end else if (timed_out) begin
                        error       <= 1'b1;
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b0;
                        timeout_cnt <= '0;
                        state       <= StIdle;
                    end else begin
                        timeout_cnt <= timeout_cnt + 1'b1;
                    end
                end
                StAck: begin
                    if (clk_fall) begin
                        timeout_cnt <= '0;
                        if (!data_filt) begin
                            done <= 1'b1;
                        end else begin
                            error <= 1'b1;
                        end
                        state <= StWaitIdle;
                    end else if (timed_out) begin
                        error       <= 1'b1;
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b0;
                        timeout_cnt <= '0;
                        state       <= StIdle;
                    end else begin
                        timeout_cnt <= timeout_cnt + 1'b1;
                    end
                end
                StWaitIdle: begin
                    if (clk_filt && data_filt) begin
                        timeout_cnt <= '0;
                        state       <= StIdle;
                    end else if (clk_fall) begin
                        timeout_cnt <= '0;
                    end else if (timed_out) begin
                        error       <= 1'b1;
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b0;
                        timeout_cnt <= '0;
                        state       <= StIdle;
                    end else begin
                        timeout_cnt <= timeout_cnt + 1'b1;
                    end
                end
                default: begin
                    ps2_clk_oe  <= 1'b0;
                    ps2_data_oe <= 1'b0;
                    state       <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_host_transmitter.sv
// Bench for ps2_host_transmitter: open-collector device model plus a scoreboard of expected
// frames and done/error outcomes checked by an independent monitor.
module tb_ps2_host_transmitter;

    localparam int unsigned INHIBIT = 20;
    localparam int unsigned SETUP   = 4;
    localparam int unsigned TIMEOUT = 2000;
    localparam int          HALF    = 25;

    logic       clock50 = 1'b0;
    logic       reset   = 1'b0;
    logic       ps2_clk_oe, ps2_data_oe;
    logic [7:0] cmd_byte = 8'h00;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready, busy, done, error;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;
    logic       ps2_clk_line, ps2_data_line;

    // Wired-AND bus: either side may pull low.
    assign ps2_clk_line  = dev_clk & ~ps2_clk_oe;
    assign ps2_data_line = dev_data & ~ps2_data_oe;

    always #10 clock50 = ~clock50;

    ps2_host_transmitter #(
        .INHIBIT_CYCLES(INHIBIT),
        .SETUP_CYCLES  (SETUP),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clock50    (clock50),
        .reset      (reset),
        .ps2_clk_in (ps2_clk_line),
        .ps2_data_in(ps2_data_line),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe),
        .cmd_byte   (cmd_byte),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    typedef struct packed {
        logic [10:0] frame;
        logic        is_done;
        logic        chk_frame;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [10:0] dev_frame = '0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic bound_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: wait expired, got no event expected one", name);
    endtask

    task automatic push_exp(input logic [10:0] frame, input logic is_done, input logic chk);
        exp_t e;
        e.frame     = frame;
        e.is_done   = is_done;
        e.chk_frame = chk;
        exp_q.push_back(e);
    endtask

    task automatic send_cmd(input logic [7:0] b);
        bit ok = 0;
        for (int i = 0; i < 400; i++) begin
            if (cmd_ready) begin
                ok = 1;
                break;
            end
            @(negedge clock50);
        end
        if (!ok) begin
            bound_fail("send_cmd_ready");
            return;
        end
        cmd_byte  = b;
        cmd_valid = 1'b1;
        @(negedge clock50);
        cmd_valid = 1'b0;
    endtask

    // Device: waits for the host request, clocks nfall falling edges, samples each host bit at
    // the end of the high phase, and drives ack_bit before the 11th edge.
    task automatic dev_xfer(input int nfall, input logic ack_bit);
        bit ok = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clock50);
            if (ps2_clk_oe) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            bound_fail("dev_inhibit");
            return;
        end
        ok = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clock50);
            if (!ps2_clk_oe) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            bound_fail("dev_release");
            return;
        end
        dev_frame[0] = ps2_data_line;
        repeat (20) @(negedge clock50);
        for (int k = 1; k <= nfall; k++) begin
            if (k == 11) begin
                dev_data = ack_bit;
                repeat (15) @(negedge clock50);
            end
            dev_clk = 1'b0;
            repeat (HALF) @(negedge clock50);
            dev_clk = 1'b1;
            repeat (HALF) @(negedge clock50);
            if (k <= 10) dev_frame[k] = ps2_data_line;
        end
        if (nfall == 11) begin
            dev_data = 1'b1;
            ok = 0;
            for (int i = 0; i < 200; i++) begin
                @(negedge clock50);
                if (!busy) begin
                    ok = 1;
                    break;
                end
            end
            if (!ok) bound_fail("dev_wait_idle");
        end
    endtask

    // Monitor: every done/error pulse consumes one scoreboard entry.
    always @(negedge clock50) begin : monitor
        exp_t e;
        if (done === 1'b1 || error === 1'b1) begin
            check("done_error_exclusive", {31'd0, done & error}, 32'd0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: got done=%0b error=%0b expected no pulse",
                         done, error);
            end else begin
                e = exp_q.pop_front();
                check("outcome_done", {31'd0, done}, {31'd0, e.is_done});
                check("outcome_error", {31'd0, error}, {31'd0, ~e.is_done});
                if (e.chk_frame) check("frame", {21'd0, dev_frame}, {21'd0, e.frame});
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int  cnt;
        bit  ok;

        repeat (5) @(negedge clock50);
        check("rst_clk_oe", {31'd0, ps2_clk_oe}, 32'd0);
        check("rst_data_oe", {31'd0, ps2_data_oe}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_error", {31'd0, error}, 32'd0);
        check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        reset = 1'b1;
        @(negedge clock50);
        check("cmd_ready_after_reset", {31'd0, cmd_ready}, 32'd1);

        // Frames are {stop, parity, data[7:0], start}.
        push_exp(11'h7DA, 1'b1, 1'b1);
        send_cmd(8'hED);
        dev_xfer(11, 1'b0);

        push_exp(11'h600, 1'b1, 1'b1);
        send_cmd(8'h00);
        dev_xfer(11, 1'b0);
        push_exp(11'h402, 1'b1, 1'b1);
        send_cmd(8'h01);
        dev_xfer(11, 1'b0);

        push_exp(11'h7FE, 1'b0, 1'b1);
        send_cmd(8'hFF);
        dev_xfer(11, 1'b1);
        check("nack_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("nack_busy", {31'd0, busy}, 32'd0);

        // Device never clocks: error exactly TIMEOUT cycles after clock release.
        push_exp(11'h000, 1'b0, 1'b0);
        send_cmd(8'h3C);
        ok = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clock50);
            if (!ps2_clk_oe) begin
                ok = 1;
                break;
            end
        end
        if (!ok) bound_fail("timeout_release");
        cnt = 0;
        ok  = 0;
        for (int i = 0; i < int'(TIMEOUT) + 50; i++) begin
            @(negedge clock50);
            cnt++;
            if (error) begin
                ok = 1;
                break;
            end
        end
        if (!ok) bound_fail("timeout_error");
        check("timeout_cycles", cnt, TIMEOUT);
        check("timeout_clk_oe", {31'd0, ps2_clk_oe}, 32'd0);
        check("timeout_data_oe", {31'd0, ps2_data_oe}, 32'd0);
        @(negedge clock50);
        check("timeout_cmd_ready", {31'd0, cmd_ready}, 32'd1);

        // Reset after the 4th edge of 0xA5: bit 3 is 0, so data is being pulled low.
        send_cmd(8'hA5);
        dev_xfer(4, 1'b0);
        check("mid_busy", {31'd0, busy}, 32'd1);
        check("mid_data_oe", {31'd0, ps2_data_oe}, 32'd1);
        reset = 1'b0;
        @(negedge clock50);
        check("abort_clk_oe", {31'd0, ps2_clk_oe}, 32'd0);
        check("abort_data_oe", {31'd0, ps2_data_oe}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        repeat (3) @(negedge clock50);
        check("abort_cmd_ready_low", {31'd0, cmd_ready}, 32'd0);
        reset = 1'b1;
        @(negedge clock50);
        check("abort_cmd_ready_high", {31'd0, cmd_ready}, 32'd1);

        // A second request while busy must be ignored.
        push_exp(11'h5E8, 1'b1, 1'b1);
        send_cmd(8'hF4);
        fork
            dev_xfer(11, 1'b0);
            begin
                repeat (100) @(negedge clock50);
                check("cmd_ready_while_busy", {31'd0, cmd_ready}, 32'd0);
                cmd_byte  = 8'h55;
                cmd_valid = 1'b1;
                @(negedge clock50);
                cmd_valid = 1'b0;
            end
        join
        repeat (60) @(negedge clock50);
        check("no_second_transfer", {31'd0, busy}, 32'd0);
        check("idle_clk_oe", {31'd0, ps2_clk_oe}, 32'd0);
        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
